// File: rtl/if_stage_if.sv
// Fetch-stage bus: control/redirect inputs, ROM port and IF/ID outputs grouped together.
// The slave side is the fetch stage; the master side is the surrounding pipeline and ROM.
interface if_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  branch_flag;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_target;
  logic                  rom_chip_enable;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_instruction;
  logic                  id_valid;

  modport slave (
    input  stall, branch_flag, branch_target, flush, flush_target, rom_data,
    output rom_chip_enable, rom_addr, id_pc, id_instruction, id_valid
  );

  modport master (
    output stall, branch_flag, branch_target, flush, flush_target, rom_data,
    input  rom_chip_enable, rom_addr, id_pc, id_instruction, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction ROM and fills IF/ID.
// One HOLD cycle after reset, then FETCH forever with flush > stall > branch > sequential.
module if_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  if_stage_if.slave   bus
);

  typedef enum logic {
    HOLD  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ce_q, ce_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic                  id_valid_q, id_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    case (state_q)
      HOLD: begin
        state_d = FETCH;
        ce_d    = 1'b1;
      end
      FETCH: begin
        if (bus.flush) begin
          pc_d       = bus.flush_target & ALIGN_MASK;
          id_pc_d    = '0;
          id_instr_d = '0;
          id_valid_d = 1'b0;
        end else if (!bus.stall) begin
          // The word fetched alongside a taken branch is its delay slot and is kept.
          id_pc_d    = pc_q;
          id_instr_d = bus.rom_data;
          id_valid_d = 1'b1;
          pc_d       = bus.branch_flag ? (bus.branch_target & ALIGN_MASK) : (pc_q + PC_STEP);
        end
      end
      default: begin
        state_d = HOLD;
        ce_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.rom_addr        = pc_q;
  assign bus.rom_chip_enable = ce_q;
  assign bus.id_pc           = id_pc_q;
  assign bus.id_instruction  = id_instr_q;
  assign bus.id_valid        = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for the fetch/stall/branch/flush sequence,
// plus hand-written sequences for reset behaviour.
module tb_if_stage;

  logic clock;
  logic reset_n;

  if_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  if_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Combinational ROM: NOP when disabled.
  assign bus.rom_data = bus.rom_chip_enable ? rom_word(bus.rom_addr) : 32'h0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] btgt;
    logic        flush;
    logic [31:0] ftgt;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                              input logic fl, input logic [31:0] ft,
                              input logic [31:0] ea, input logic ece,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    vec_t v;
    v.stall = st; v.branch = br; v.btgt = bt; v.flush = fl; v.ftgt = ft;
    v.e_addr = ea; v.e_ce = ece; v.e_pc = ep; v.e_instr = ei; v.e_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ea, input logic ece,
                           input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    n_vec++;
    check({tag, " rom_addr"}, bus.rom_addr, ea);
    check({tag, " ce"}, {31'b0, bus.rom_chip_enable}, {31'b0, ece});
    check({tag, " id_pc"}, bus.id_pc, ep);
    check({tag, " id_instr"}, bus.id_instruction, ei);
    check({tag, " id_valid"}, {31'b0, bus.id_valid}, {31'b0, ev});
    $display("%s addr=%h ce=%b id_pc=%h id_instr=%h id_valid=%b", tag, bus.rom_addr,
             bus.rom_chip_enable, bus.id_pc, bus.id_instruction, bus.id_valid);
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] ft);
    bus.stall = st; bus.branch_flag = br; bus.branch_target = bt;
    bus.flush = fl; bus.flush_target = ft;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    // HOLD ignores everything, even a flush.
    vecs.push_back(mk(1, 1, 32'h200, 1, 32'h100, 32'h0, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h4, 1, 32'h0, rom_word(32'h0), 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h8, 1, 32'h4, rom_word(32'h4), 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'hC, 1, 32'h8, rom_word(32'h8), 1));
    // Three stall cycles: everything holds.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 32'h0, 0, 32'h0, 32'hC, 1, 32'h8, rom_word(32'h8), 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h10, 1, 32'hC, rom_word(32'hC), 1));
    // Branch at pc=0x10: delay slot kept, redirect to 0x40.
    vecs.push_back(mk(0, 1, 32'h40, 0, 32'h0, 32'h40, 1, 32'h10, rom_word(32'h10), 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h44, 1, 32'h40, rom_word(32'h40), 1));
    // Stall beats branch.
    vecs.push_back(mk(1, 1, 32'h200, 0, 32'h0, 32'h44, 1, 32'h40, rom_word(32'h40), 1));
    // Flush beats stall and branch.
    vecs.push_back(mk(1, 1, 32'h200, 1, 32'h180, 32'h180, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h184, 1, 32'h180, rom_word(32'h180), 1));
    // Misaligned branch target is forced aligned.
    vecs.push_back(mk(0, 1, 32'h43, 0, 32'h0, 32'h40, 1, 32'h184, rom_word(32'h184), 1));
    // Misaligned flush target, then wrap from the top of the address space.
    vecs.push_back(mk(0, 0, 32'h0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 32'h0, 32'h4, 1, 32'h0, rom_word(32'h0), 1));

    drive(0, 0, 32'h0, 0, 32'h0);
    reset_n = 1'b0;
    #22;
    check_all("reset", 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_all("hold", 32'h0, 0, 32'h0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].branch, vecs[i].btgt, vecs[i].flush, vecs[i].ftgt);
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ce,
                vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid);
    end

    // Asynchronous reset mid-stream: outputs clear with no clock edge.
    drive(0, 1, 32'h300, 0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clock);
    #1;
    check_all("rst_held", 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 1, 32'h300, 1, 32'h400);
    #1;
    check_all("hold2_pre", 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clock);
    #1;
    check_all("hold2_exit", 32'h0, 1, 32'h0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 32'h0);
    @(posedge clock);
    #1;
    check_all("refetch", 32'h4, 1, 32'h0, rom_word(32'h0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
